// File: rtl/rps_pkg.sv
// Shared encodings, FSM state type and defaults for the rock-paper-scissors round sequencer.
// The judge and the predictor's reward logic both import this package.
package rps_pkg;

    localparam logic [1:0] ROCK    = 2'b00;
    localparam logic [1:0] SCISSOR = 2'b01;
    localparam logic [1:0] PAPER   = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam logic [1:0] TIE      = 2'b00;
    localparam logic [1:0] USER_WIN = 2'b01;
    localparam logic [1:0] COMP_WIN = 2'b10;

    localparam int MAX_GAMES_DEF = 60;
    localparam int CNT_W         = 6;
    localparam int WAIT_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRED,
        COMMIT,
        SCORE,
        DONE
    } state_t;

    // True when throw a defeats throw b (legal throws only).
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == ROCK)    && (b == SCISSOR)) ||
               ((a == SCISSOR) && (b == PAPER))   ||
               ((a == PAPER)   && (b == ROCK));
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational win/lose judgement for one round; an illegal computer throw forfeits to the user.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] user,
    input  logic [1:0] comp,
    output logic [1:0] outcome
);

    always_comb begin
        outcome = COMP_WIN;
        if (comp == ILLEGAL) begin
            outcome = USER_WIN;
        end else if (user == comp) begin
            outcome = TIE;
        end else if (beats(user, comp)) begin
            outcome = USER_WIN;
        end
    end

endmodule

// File: rtl/rps_round_sequencer.sv
// Round sequencer: latches the user's throw, waits for the predictor, pulses start low once,
// scores the round and keeps the match tallies until MAX_GAMES rounds are played.
module rps_round_sequencer
    import rps_pkg::*;
#(
    parameter int MAX_GAMES = MAX_GAMES_DEF,
    parameter int TIMEOUT   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [1:0]       key_choice,
    input  logic [1:0]       pred_choice,
    input  logic             pred_ready,
    output logic [1:0]       user_choice,
    output logic             start,
    output logic [1:0]       comp_choice,
    output logic [1:0]       outcome,
    output logic             outcome_valid,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] game_count,
    output logic             busy,
    output logic             game_over,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0]  MAX_GAMES_C = CNT_W'(MAX_GAMES);
    localparam logic [WAIT_W-1:0] TIMEOUT_C   = WAIT_W'(TIMEOUT);

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [1:0]         user_q;
    logic [1:0]         comp_q;
    logic [1:0]         outcome_q;
    logic               outcome_valid_q;
    logic               start_q;
    logic [CNT_W-1:0]   wins_q;
    logic [CNT_W-1:0]   losses_q;
    logic [CNT_W-1:0]   ties_q;
    logic [CNT_W-1:0]   game_count_q;
    logic               busy_q;
    logic               game_over_q;
    logic               timeout_q;

    logic [1:0]         outcome_d;
    logic [CNT_W-1:0]   game_count_d;

    rps_judge u_judge (
        .user    (user_q),
        .comp    (comp_q),
        .outcome (outcome_d)
    );

    assign game_count_d = game_count_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            wait_q          <= '0;
            user_q          <= ROCK;
            comp_q          <= ROCK;
            outcome_q       <= TIE;
            outcome_valid_q <= 1'b0;
            start_q         <= 1'b1;
            wins_q          <= '0;
            losses_q        <= '0;
            ties_q          <= '0;
            game_count_q    <= '0;
            busy_q          <= 1'b0;
            game_over_q     <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            outcome_valid_q <= 1'b0;
            start_q         <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (key_valid && (key_choice != ILLEGAL)) begin
                        user_q  <= key_choice;
                        wait_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_PRED;
                    end
                end
                WAIT_PRED: begin
                    // start is registered, so it drops on the same edge that enters COMMIT.
                    if (pred_ready) begin
                        comp_q  <= pred_choice;
                        start_q <= 1'b0;
                        state_q <= COMMIT;
                    end else if (wait_q == TIMEOUT_C) begin
                        timeout_q <= 1'b1;
                        comp_q    <= pred_choice;
                        start_q   <= 1'b0;
                        state_q   <= COMMIT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                COMMIT: begin
                    outcome_q       <= outcome_d;
                    outcome_valid_q <= 1'b1;
                    game_count_q    <= game_count_d;
                    case (outcome_d)
                        TIE:      ties_q   <= ties_q + 1'b1;
                        USER_WIN: wins_q   <= wins_q + 1'b1;
                        default:  losses_q <= losses_q + 1'b1;
                    endcase
                    if (game_count_d == MAX_GAMES_C) begin
                        game_over_q <= 1'b1;
                    end
                    state_q <= SCORE;
                end
                SCORE: begin
                    if (game_over_q) begin
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign user_choice   = user_q;
    assign start         = start_q;
    assign comp_choice   = comp_q;
    assign outcome       = outcome_q;
    assign outcome_valid = outcome_valid_q;
    assign wins          = wins_q;
    assign losses        = losses_q;
    assign ties          = ties_q;
    assign game_count    = game_count_q;
    assign busy          = busy_q;
    assign game_over     = game_over_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_rps_round_sequencer.sv
// Directed scoreboard bench for rps_round_sequencer: stimulus pushes expected round results,
// a negedge monitor pops and compares them whenever outcome_valid is seen.
module tb_rps_round_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_choice = 2'b00;
    logic [1:0] pred_choice = 2'b00;
    logic       pred_ready = 1'b0;
    logic [1:0] user_choice;
    logic       start;
    logic [1:0] comp_choice;
    logic [1:0] outcome;
    logic       outcome_valid;
    logic [5:0] wins, losses, ties, game_count;
    logic       busy, game_over, timeout_err;

    rps_round_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_choice    (key_choice),
        .pred_choice   (pred_choice),
        .pred_ready    (pred_ready),
        .user_choice   (user_choice),
        .start         (start),
        .comp_choice   (comp_choice),
        .outcome       (outcome),
        .outcome_valid (outcome_valid),
        .wins          (wins),
        .losses        (losses),
        .ties          (ties),
        .game_count    (game_count),
        .busy          (busy),
        .game_over     (game_over),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] out;
        logic [1:0] comp;
        logic [5:0] w;
        logic [5:0] l;
        logic [5:0] t;
        logic [5:0] gc;
    } exp_s;

    exp_s       sb_q[$];
    exp_s       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_pop = 0;
    int         n_start = 0;
    int         snap;
    logic [5:0] ew = '0, el = '0, et = '0, egc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per outcome_valid pulse.
    always @(negedge clock) begin
        if (!reset && outcome_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got outcome_valid=1, want no round pending");
            end else begin
                mon_e = sb_q.pop_front();
                check("round_result", {outcome, comp_choice, wins, losses, ties, game_count}, mon_e);
                check("tally_sum", 32'(wins) + 32'(losses) + 32'(ties), 32'(game_count));
            end
            n_pop++;
        end
    end

    always @(negedge clock) begin
        if (!reset && start === 1'b0) n_start++;
    end

    task automatic push(input logic [1:0] out, input logic [1:0] comp);
        case (out)
            2'b00:   et = et + 1'b1;
            2'b01:   ew = ew + 1'b1;
            default: el = el + 1'b1;
        endcase
        egc = egc + 1'b1;
        sb_q.push_back('{out: out, comp: comp, w: ew, l: el, t: et, gc: egc});
    endtask

    task automatic wait_pop(input int tgt, input int budget);
        for (int i = 0; i < budget && n_pop < tgt; i++) @(negedge clock);
        if (n_pop < tgt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_outcome: got %0d results, want %0d within %0d cycles", n_pop, tgt, budget);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_start", start, 1);
        check("rst_outcome_valid", outcome_valid, 0);
        check("rst_choices", {user_choice, comp_choice, outcome}, 0);
        check("rst_counters", {wins, losses, ties, game_count}, 0);
        check("rst_flags", {busy, game_over, timeout_err}, 0);
    endtask

    // Asserts reset between edges, checks it took effect without a clock, releases on a negedge.
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        key_valid = 1'b0;
        #1 check_reset_vals();
        sb_q.delete();
        ew = '0; el = '0; et = '0; egc = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic play(input logic [1:0] u, input logic [1:0] p, input logic [1:0] out,
                        input logic rdy, input int budget);
        int tgt;
        tgt = n_pop + 1;
        push(out, p);
        @(negedge clock);
        key_valid = 1'b1; key_choice = u; pred_choice = p; pred_ready = rdy;
        @(negedge clock);
        key_valid = 1'b0;
        wait_pop(tgt, budget);
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, want bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        // Reset, then first key honoured on the first edge after release: rock vs paper.
        do_reset();
        push(2'b10, 2'b10);
        tgt = n_pop + 1;
        key_valid = 1'b1; key_choice = 2'b00; pred_ready = 1'b1; pred_choice = 2'b10;
        @(negedge clock);
        key_valid = 1'b0;
        check("c1_busy", busy, 1);
        check("c1_start_high", start, 1);
        @(negedge clock);
        check("c2_start_low", start, 0);
        check("c2_no_valid", outcome_valid, 0);
        @(negedge clock);
        check("c3_outcome_valid", outcome_valid, 1);
        wait_pop(tgt, 5);
        @(negedge clock);
        check("hold_after_score", {outcome_valid, busy, outcome, comp_choice}, {1'b0, 1'b0, 2'b10, 2'b10});

        // Illegal key in IDLE is ignored.
        snap = n_start;
        key_valid = 1'b1; key_choice = 2'b11;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        check("illegal_busy", busy, 0);
        @(negedge clock);
        check("illegal_no_start", n_start, snap);
        check("illegal_counters", {wins, losses, ties, game_count}, {6'd0, 6'd1, 6'd0, 6'd1});

        // Re-strobe during WAIT_PRED: scissor latched, paper ignored, scissor vs scissor tie.
        snap = n_start;
        tgt = n_pop + 1;
        push(2'b00, 2'b01);
        key_valid = 1'b1; key_choice = 2'b01; pred_ready = 1'b0; pred_choice = 2'b01;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        key_valid = 1'b1; key_choice = 2'b10;
        @(negedge clock);
        key_valid = 1'b0;
        check("restrobe_user", user_choice, 2'b01);
        check("restrobe_busy", busy, 1);
        pred_ready = 1'b1;
        wait_pop(tgt, 10);
        @(negedge clock);
        @(negedge clock);
        check("restrobe_one_start", n_start, snap + 1);

        // Predictor never ready: timeout, illegal computer throw scored as user win.
        play(2'b10, 2'b11, 2'b01, 1'b0, 400);
        check("timeout_err", timeout_err, 1);
        check("timeout_counters", {wins, losses, ties, game_count}, {6'd1, 6'd1, 6'd1, 6'd3});

        // Reset while waiting for the predictor abandons the round.
        key_valid = 1'b1; key_choice = 2'b00; pred_ready = 1'b0;
        @(negedge clock);
        key_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("wait_pred_busy", busy, 1);
        snap = n_start;
        do_reset();
        push(2'b01, 2'b10);
        tgt = n_pop + 1;
        key_valid = 1'b1; key_choice = 2'b01; pred_ready = 1'b1; pred_choice = 2'b10;
        @(negedge clock);
        key_valid = 1'b0;
        wait_pop(tgt, 10);
        @(negedge clock);
        check("post_reset_one_start", n_start, snap + 1);
        check("post_reset_count", game_count, 1);

        // Full match: alternate tie (rock/rock) and user win (rock/scissor).
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) play(2'b00, 2'b00, 2'b00, 1'b1, 10);
            else            play(2'b00, 2'b01, 2'b01, 1'b1, 10);
        end
        @(negedge clock);
        check("match_tallies", {wins, losses, ties, game_count}, {6'd30, 6'd0, 6'd30, 6'd60});
        check("match_game_over", {game_over, busy}, 2'b11);
        snap = n_start;
        key_valid = 1'b1; key_choice = 2'b10; pred_ready = 1'b1; pred_choice = 2'b00;
        @(negedge clock);
        key_valid = 1'b0;
        repeat (8) @(negedge clock);
        check("done_no_start", n_start, snap);
        check("done_count_held", {game_over, game_count}, {1'b1, 6'd60});
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
